// File: rtl/uart_ram_loader_if.sv
// ============================================================================
// Module   : uart_ram_loader_if
// Purpose  : Byte handshake bundle between a UART rx/tx pair and the loader.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_ram_loader_if;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_ready_clear;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       tx_busy;

    // master: the loader, which drains the receiver and drives the transmitter
    modport master (
        input  rx_data,
        input  rx_ready,
        input  tx_busy,
        output rx_ready_clear,
        output tx_data,
        output tx_en
    );

    modport slave (
        output rx_data,
        output rx_ready,
        output tx_busy,
        input  rx_ready_clear,
        input  tx_data,
        input  tx_en
    );
endinterface

`default_nettype wire

// File: rtl/uart_ram_loader.sv
// ============================================================================
// Module   : uart_ram_loader
// Purpose  : Decodes 'W' addr len data... packets from a UART into a byte RAM,
//            acknowledges with ACK/NAK and exposes a registered read port.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_ram_loader #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 3000000
) (
    input  wire logic              sys_clk,
    input  wire logic              rst,
    uart_ram_loader_if.master      uart,
    input  wire logic [ADDR_W-1:0] rd_addr,
    output logic      [7:0]        rd_data,
    output logic                   pkt_done,
    output logic                   pkt_err
);

    localparam int              c_depth   = 1 << ADDR_W;
    localparam int              c_rem_w   = ADDR_W + 1;
    localparam int              c_cnt_w   = $clog2(TIMEOUT + 1);
    localparam logic [7:0]      c_sync    = 8'h57;
    localparam logic [7:0]      c_ack     = 8'h06;
    localparam logic [7:0]      c_nak     = 8'h15;
    localparam logic [c_cnt_w-1:0] c_tmo    = c_cnt_w'(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_tmo_m1 = c_cnt_w'(TIMEOUT - 1);
    localparam logic [c_rem_w-1:0] c_full   = c_rem_w'(c_depth);
    localparam logic [c_rem_w-1:0] c_one    = c_rem_w'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_LEN  = 3'd2,
        S_DATA = 3'd3,
        S_ACK  = 3'd4,
        S_NAK  = 3'd5
    } state_t;

    state_t               r_state;
    logic                 r_clear;
    logic                 r_tx_en;
    logic [7:0]           r_tx_data;
    logic [ADDR_W-1:0]    r_ptr;
    logic [c_rem_w-1:0]   r_remain;
    logic [c_cnt_w-1:0]   r_idle;
    logic                 r_done;
    logic                 r_err;
    logic [7:0]           r_rd_data;
    logic [7:0]           r_mem [c_depth];

    logic w_rx_open;
    logic w_timed_out;
    logic w_accept;
    logic w_wr;

    // Once the idle counter has hit TIMEOUT the packet is dead; a late byte stays pending.
    assign w_rx_open   = (r_state == S_IDLE) || (r_state == S_ADDR) ||
                         (r_state == S_LEN)  || (r_state == S_DATA);
    assign w_timed_out = (r_idle == c_tmo);
    assign w_accept    = uart.rx_ready && !r_clear && w_rx_open && !w_timed_out;
    assign w_wr        = w_accept && (r_state == S_DATA);

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_clear   <= 1'b0;
            r_tx_en   <= 1'b0;
            r_tx_data <= 8'h00;
            r_ptr     <= '0;
            r_remain  <= '0;
            r_idle    <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;

            if (w_accept) begin
                r_clear <= 1'b1;
            end else if (r_clear && !uart.rx_ready) begin
                r_clear <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_idle <= '0;
                    if (w_accept && (uart.rx_data == c_sync)) begin
                        r_state <= S_ADDR;
                    end
                end
                S_ADDR, S_LEN, S_DATA: begin
                    if (w_accept) begin
                        r_idle <= '0;
                        if (r_state == S_ADDR) begin
                            r_ptr   <= ADDR_W'(uart.rx_data);
                            r_state <= S_LEN;
                        end else if (r_state == S_LEN) begin
                            r_remain <= (uart.rx_data == 8'h00) ? c_full
                                                                : c_rem_w'(uart.rx_data);
                            r_state  <= S_DATA;
                        end else begin
                            r_ptr    <= r_ptr + 1'b1;
                            r_remain <= r_remain - 1'b1;
                            if (r_remain == c_one) begin
                                r_state   <= S_ACK;
                                r_tx_en   <= 1'b1;
                                r_tx_data <= c_ack;
                                r_done    <= 1'b1;
                            end
                        end
                    end else if (w_timed_out) begin
                        r_idle    <= '0;
                        r_state   <= S_NAK;
                        r_tx_en   <= 1'b1;
                        r_tx_data <= c_nak;
                    end else begin
                        r_idle <= r_idle + 1'b1;
                        if (r_idle == c_tmo_m1) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_ACK, S_NAK: begin
                    if (r_tx_en) begin
                        if (uart.tx_busy) begin
                            r_tx_en <= 1'b0;
                        end
                    end else if (!uart.tx_busy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge sys_clk) begin
        if (w_wr) begin
            r_mem[r_ptr] <= uart.rx_data;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_rd_data <= 8'h00;
        end else begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign uart.rx_ready_clear = r_clear;
    assign uart.tx_en          = r_tx_en;
    assign uart.tx_data        = r_tx_data;
    assign rd_data             = r_rd_data;
    assign pkt_done            = r_done;
    assign pkt_err             = r_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_ram_loader.sv
// ============================================================================
// Module   : tb_uart_ram_loader
// Purpose  : Directed self-checking bench for uart_ram_loader.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_ram_loader;

    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        pkt_done;
    logic        pkt_err;

    uart_ram_loader_if u_if ();

    uart_ram_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .sys_clk  (clk),
        .rst      (rst),
        .uart     (u_if),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .pkt_done (pkt_done),
        .pkt_err  (pkt_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0, clr_rises = 0, last_clr_cyc = 0;
    int done_cnt = 0, done_cyc = 0, err_cnt = 0, err_cyc = 0, tx_rise_cyc = 0;
    int tx_cnt = 0, tx_drop = 0, tx_stuck = 0;
    logic [7:0] last_tx = 8'h00;
    logic prev_clr = 1'b0, prev_txen = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Event monitor: time-stamps clear rises, done/err pulses and tx_en rises.
    initial begin
        forever begin
            tick();
            cyc++;
            if (u_if.rx_ready_clear && !prev_clr) begin
                clr_rises++;
                last_clr_cyc = cyc;
            end
            if (pkt_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (pkt_err) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (u_if.tx_en && !prev_txen) tx_rise_cyc = cyc;
            prev_clr  = u_if.rx_ready_clear;
            prev_txen = u_if.tx_en;
        end
    end

    // Transmitter model: delays busy by 3 cycles to prove tx_en is held.
    initial begin
        u_if.tx_busy = 1'b0;
        forever begin
            tick();
            if (u_if.tx_en) begin
                tx_cnt++;
                last_tx = u_if.tx_data;
                repeat (3) begin
                    tick();
                    if (!u_if.tx_en) tx_drop++;
                end
                u_if.tx_busy = 1'b1;
                tick();
                if (u_if.tx_en) tx_stuck++;
                repeat (3) tick();
                u_if.tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        while (u_if.rx_ready_clear && n < 200) begin
            tick();
            n++;
        end
        u_if.rx_data  = b;
        u_if.rx_ready = 1'b1;
        n = 0;
        tick();
        while (!u_if.rx_ready_clear && n < 200) begin
            tick();
            n++;
        end
        check("byte_accepted", u_if.rx_ready_clear, 1);
        u_if.rx_ready = 1'b0;
    endtask

    task automatic wait_tx_done(input int exp_cnt);
        int n;
        n = 0;
        while (!(tx_cnt == exp_cnt && !u_if.tx_busy && !u_if.tx_en) && n < 300) begin
            tick();
            n++;
        end
        check("tx_count", tx_cnt, exp_cnt);
        repeat (2) tick();
    endtask

    task automatic read_ram(input logic [7:0] a, output logic [7:0] d);
        rd_addr = a;
        tick();
        d = rd_data;
    endtask

    logic [7:0] d;
    int bad, rises0, n;

    initial begin
        rst = 1'b1;
        rd_addr = 8'h00;
        u_if.rx_data  = 8'h00;
        u_if.rx_ready = 1'b0;
        repeat (3) tick();
        check("rst_rx_clear", u_if.rx_ready_clear, 0);
        check("rst_tx_en",    u_if.tx_en, 0);
        check("rst_tx_data",  u_if.tx_data, 8'h00);
        check("rst_pkt_done", pkt_done, 0);
        check("rst_pkt_err",  pkt_err, 0);
        check("rst_rd_data",  rd_data, 8'h00);
        rst = 1'b0;
        tick();

        // Basic 3-byte packet
        send_byte(8'h57); send_byte(8'h10); send_byte(8'h03);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        tick();
        check("done_after_last_byte", done_cyc, last_clr_cyc);
        check("tx_en_with_done", tx_rise_cyc, done_cyc);
        wait_tx_done(1);
        check("ack_byte", last_tx, 8'h06);
        check("done_count_1", done_cnt, 1);
        read_ram(8'h10, d); check("ram_10", d, 8'hAA);
        read_ram(8'h11, d); check("ram_11", d, 8'hBB);
        read_ram(8'h12, d); check("ram_12", d, 8'hCC);

        // Read-first on a same-address write
        rd_addr = 8'h10;
        send_byte(8'h57); send_byte(8'h10); send_byte(8'h01);
        send_byte(8'hEE);
        check("read_first_old", rd_data, 8'hAA);
        tick();
        check("read_first_new", rd_data, 8'hEE);
        wait_tx_done(2);

        // L=0 means a full 256-byte packet
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
        for (int i = 0; i < 256; i++) send_byte(8'(i));
        wait_tx_done(3);
        check("done_count_full", done_cnt, 3);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            read_ram(8'(i), d);
            if (d !== 8'(i)) bad++;
        end
        check("full_ram_bad_entries", bad, 0);

        // Address wrap, then bytes offered during the ACK stay pending
        send_byte(8'h57); send_byte(8'hFE); send_byte(8'h04);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        rises0 = clr_rises;
        send_byte(8'h41);
        check("pending_after_ack_cnt", tx_cnt, 4);
        check("pending_after_ack_busy", u_if.tx_busy, 0);
        send_byte(8'h42);
        repeat (6) tick();
        check("discard_no_tx", tx_cnt, 4);
        check("discard_no_done", done_cnt, 4);
        send_byte(8'h57); send_byte(8'h20); send_byte(8'h01); send_byte(8'h5A);
        wait_tx_done(5);
        check("clear_once_per_byte", clr_rises - rises0, 6);
        read_ram(8'hFE, d); check("ram_FE", d, 8'h01);
        read_ram(8'hFF, d); check("ram_FF", d, 8'h02);
        read_ram(8'h00, d); check("ram_00", d, 8'h03);
        read_ram(8'h01, d); check("ram_01", d, 8'h04);
        read_ram(8'h20, d); check("ram_20", d, 8'h5A);

        // Timeout mid-packet: counter reads 0 the cycle clear rises, hits TIMEOUT 100 later
        send_byte(8'h57); send_byte(8'h30); send_byte(8'h05); send_byte(8'h11);
        n = 0;
        while (err_cnt == 0 && n < 300) begin
            tick();
            n++;
        end
        repeat (2) tick();
        check("err_latency", err_cyc - last_clr_cyc, TIMEOUT);
        check("nak_tx_en_after_err", tx_rise_cyc, err_cyc + 1);
        wait_tx_done(6);
        check("nak_byte", last_tx, 8'h15);
        check("err_single_pulse", err_cnt, 1);
        check("no_done_on_timeout", done_cnt, 5);
        read_ram(8'h30, d); check("ram_30", d, 8'h11);
        read_ram(8'h31, d); check("ram_31_kept", d, 8'h31);

        // Reset mid-packet
        send_byte(8'h57); send_byte(8'h40);
        rst = 1'b1;
        tick();
        check("midrst_rx_clear", u_if.rx_ready_clear, 0);
        check("midrst_tx_en",    u_if.tx_en, 0);
        check("midrst_tx_data",  u_if.tx_data, 8'h00);
        check("midrst_rd_data",  rd_data, 8'h00);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("midrst_no_err", err_cnt, 1);
        check("midrst_no_tx", tx_cnt, 6);
        send_byte(8'h57); send_byte(8'h40); send_byte(8'h01); send_byte(8'h77);
        wait_tx_done(7);
        check("post_rst_ack", last_tx, 8'h06);
        check("post_rst_done", done_cnt, 6);
        read_ram(8'h40, d); check("ram_40", d, 8'h77);

        check("tx_en_dropped_early", tx_drop, 0);
        check("tx_en_stuck_on_busy", tx_stuck, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
